// File: rtl/traffic_phase_ctrl.sv
// Two-road phase scheduler: green/yellow/all-red sequencing, countdown displays, pedestrian
// shortening and writable durations. Define NIGHT_FLASH_EN to add the night flashing mode.
module traffic_phase_ctrl #(
  parameter int unsigned T_G1_DEF  = 30,
  parameter int unsigned T_G2_DEF  = 25,
  parameter int unsigned T_Y_DEF   = 3,
  parameter int unsigned T_AR_DEF  = 2,
  parameter int unsigned T_PED_MIN = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       ped_req_1,
  input  logic       ped_req_2,
`ifdef NIGHT_FLASH_EN
  input  logic       night,
`endif
  output logic       ped_ack_1,
  output logic       ped_ack_2,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [6:0] cfg_data,
  output logic [2:0] light_1,
  output logic [2:0] light_2,
  output logic [6:0] time_dis_1,
  output logic [6:0] time_dis_2
);

  typedef enum logic [2:0] {
    StAr0, StG1, StY1, StAr1, StG2, StY2, StAr2
`ifdef NIGHT_FLASH_EN
    , StFlash
`endif
  } state_e;

  localparam logic [6:0] PedMin = 7'(T_PED_MIN);

  state_e     state_q, state_d, nxt;
  logic [6:0] cnt_q, cnt_d, load_val;
  logic [6:0] dur_q [4];
  logic [6:0] dur_d [4];
  logic       pend_1_q, pend_1_d, pend_2_q, pend_2_d;
  logic       cut_q, cut_d, ped_cut;
  logic       ack_1_d, ack_2_d;
  logic [2:0] light_1_d, light_2_d;
  logic [6:0] time_dis_1_d, time_dis_2_d;
  logic [8:0] sum_1, sum_2;
`ifdef NIGHT_FLASH_EN
  logic       flash_q, flash_d;
`endif

  function automatic state_e succ(state_e s);
    case (s)
      StG1:    return StY1;
      StY1:    return StAr1;
      StAr1:   return StG2;
      StG2:    return StY2;
      StY2:    return StAr2;
      default: return StG1;
    endcase
  endfunction

  // Duration registers: 0 G1, 1 G2, 2 yellow, 3 all-red; a zero write means one second.
  always_comb begin
    dur_d = dur_q;
    if (cfg_we) dur_d[cfg_addr] = (cfg_data == 7'd0) ? 7'd1 : cfg_data;
  end

  always_comb begin
    case (nxt)
      StG1:       load_val = dur_q[0];
      StG2:       load_val = dur_q[1];
      StY1, StY2: load_val = dur_q[2];
      default:    load_val = dur_q[3];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StAr0;
      cnt_q      <= 7'(T_AR_DEF);
      dur_q[0]   <= 7'(T_G1_DEF);
      dur_q[1]   <= 7'(T_G2_DEF);
      dur_q[2]   <= 7'(T_Y_DEF);
      dur_q[3]   <= 7'(T_AR_DEF);
      pend_1_q   <= 1'b0;
      pend_2_q   <= 1'b0;
      cut_q      <= 1'b0;
`ifdef NIGHT_FLASH_EN
      flash_q    <= 1'b0;
`endif
      light_1    <= 3'b100;
      light_2    <= 3'b100;
      time_dis_1 <= 7'(T_AR_DEF);
      time_dis_2 <= 7'(T_AR_DEF);
      ped_ack_1  <= 1'b0;
      ped_ack_2  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dur_q      <= dur_d;
      pend_1_q   <= pend_1_d;
      pend_2_q   <= pend_2_d;
      cut_q      <= cut_d;
`ifdef NIGHT_FLASH_EN
      flash_q    <= flash_d;
`endif
      light_1    <= light_1_d;
      light_2    <= light_2_d;
      time_dis_1 <= time_dis_1_d;
      time_dis_2 <= time_dis_2_d;
      ped_ack_1  <= ack_1_d;
      ped_ack_2  <= ack_2_d;
    end
  end

  always_comb begin
    nxt      = succ(state_q);
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_1_d = pend_1_q | ped_req_1;
    pend_2_d = pend_2_q | ped_req_2;
    cut_d    = cut_q;
    ack_1_d  = 1'b0;
    ack_2_d  = 1'b0;
    // A pending crossing shortens the conflicting road's green once.
    ped_cut  = !cut_q && (cnt_q > PedMin) &&
               ((state_q == StG1 && (pend_2_q || ped_req_2)) ||
                (state_q == StG2 && (pend_1_q || ped_req_1)));
    if (tick && cnt_q == 7'd1) begin
      state_d = nxt;
      cnt_d   = load_val;
      if (nxt == StG1 || nxt == StG2) cut_d = 1'b0;
      if (nxt == StG2 && pend_1_q) begin
        ack_1_d  = 1'b1;
        pend_1_d = 1'b0;
      end
      if (nxt == StG1 && pend_2_q) begin
        ack_2_d  = 1'b1;
        pend_2_d = 1'b0;
      end
    end else if (ped_cut) begin
      cnt_d = PedMin;
      cut_d = 1'b1;
    end else if (tick) begin
      cnt_d = cnt_q - 7'd1;
    end
`ifdef NIGHT_FLASH_EN
    flash_d = flash_q;
    if (night) begin
      state_d  = StFlash;
      cnt_d    = cnt_q;
      cut_d    = cut_q;
      pend_1_d = 1'b0;
      pend_2_d = 1'b0;
      ack_1_d  = 1'b0;
      ack_2_d  = 1'b0;
      flash_d  = (state_q == StFlash) ? (flash_q ^ tick) : 1'b1;
    end else if (state_q == StFlash) begin
      state_d  = StAr0;
      cnt_d    = dur_q[3];
      cut_d    = 1'b0;
      pend_1_d = 1'b0;
      pend_2_d = 1'b0;
      ack_1_d  = 1'b0;
      ack_2_d  = 1'b0;
    end
`endif
  end

  // Outputs are computed from next-state values so they are registered yet track state exactly.
  always_comb begin
    light_1_d = 3'b100;
    light_2_d = 3'b100;
    sum_1     = 9'(cnt_d);
    sum_2     = 9'(cnt_d);
    case (state_d)
      StG1: begin
        light_1_d = 3'b001;
        sum_1     = 9'(cnt_d) + 9'(dur_d[2]);
        sum_2     = 9'(cnt_d) + 9'(dur_d[2]) + 9'(dur_d[3]);
      end
      StY1: begin
        light_1_d = 3'b010;
        sum_2     = 9'(cnt_d) + 9'(dur_d[3]);
      end
      StAr1: sum_1 = 9'(cnt_d) + 9'(dur_d[1]) + 9'(dur_d[2]) + 9'(dur_d[3]);
      StG2: begin
        light_2_d = 3'b001;
        sum_2     = 9'(cnt_d) + 9'(dur_d[2]);
        sum_1     = 9'(cnt_d) + 9'(dur_d[2]) + 9'(dur_d[3]);
      end
      StY2: begin
        light_2_d = 3'b010;
        sum_1     = 9'(cnt_d) + 9'(dur_d[3]);
      end
      StAr2: sum_2 = 9'(cnt_d) + 9'(dur_d[0]) + 9'(dur_d[2]) + 9'(dur_d[3]);
`ifdef NIGHT_FLASH_EN
      StFlash: begin
        light_1_d = flash_d ? 3'b010 : 3'b000;
        light_2_d = flash_d ? 3'b010 : 3'b000;
        sum_1     = 9'd0;
        sum_2     = 9'd0;
      end
`endif
      default: ;
    endcase
    time_dis_1_d = (sum_1 > 9'd99) ? 7'd99 : sum_1[6:0];
    time_dis_2_d = (sum_2 > 9'd99) ? 7'd99 : sum_2[6:0];
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: constant vector table, directed corner sequences and random
// stimulus against a phase-table reference model. Honors NIGHT_FLASH_EN when defined.
module tb_traffic_phase_ctrl;

  localparam int TG1 = 30, TG2 = 25, TY = 3, TAR = 2, PMIN = 5;

  logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
  logic       ped_req_1 = 1'b0, ped_req_2 = 1'b0, cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [6:0] cfg_data = '0;
  logic       ped_ack_1, ped_ack_2;
  logic [2:0] light_1, light_2;
  logic [6:0] time_dis_1, time_dis_2;
`ifdef NIGHT_FLASH_EN
  logic       night = 1'b0;
`endif

  traffic_phase_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .ped_req_1  (ped_req_1),
    .ped_req_2  (ped_req_2),
`ifdef NIGHT_FLASH_EN
    .night      (night),
`endif
    .ped_ack_1  (ped_ack_1),
    .ped_ack_2  (ped_ack_2),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .light_1    (light_1),
    .light_2    (light_2),
    .time_dis_1 (time_dis_1),
    .time_dis_2 (time_dis_2)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int ack_cnt [2];

  // Reference model: phases 0 AR0,1 G1,2 Y1,3 AR1,4 G2,5 Y2,6 AR2,7 flash.
  int ph, mcnt, mcut, mflash;
  int mdur [4];
  int mpend [2];
  int nxt_tab [7]  = '{1, 2, 3, 4, 5, 6, 1};
  int didx_tab [7] = '{3, 0, 2, 3, 1, 2, 3};
  int green_of [2] = '{1, 4};
  int yel_of [2]   = '{2, 5};

  typedef struct {
    int ticks;
    int l1;
    int l2;
    int d1;
    int d2;
  } vec_t;
  vec_t tab [10];

  function automatic bit is_red(int road, int p);
    return p != green_of[road] && p != yel_of[road];
  endfunction

  // Countdown = time until this road's red/not-red status next changes.
  function automatic int disp(int road);
    int t, p;
    bit r0;
    if (ph == 7) return 0;
    if (ph == 0) return mcnt;
    t  = mcnt;
    p  = ph;
    r0 = is_red(road, ph);
    for (int k = 0; k < 6; k++) begin
      p = nxt_tab[p];
      if (is_red(road, p) != r0) break;
      t += mdur[didx_tab[p]];
    end
    return (t > 99) ? 99 : t;
  endfunction

  function automatic int lamp(int road);
    if (ph == 7) return (mflash != 0) ? 3'b010 : 3'b000;
    if (ph == green_of[road]) return 3'b001;
    if (ph == yel_of[road]) return 3'b010;
    return 3'b100;
  endfunction

  function automatic bit night_now();
`ifdef NIGHT_FLASH_EN
    return night;
`else
    return 1'b0;
`endif
  endfunction

  int mack [2];

  task automatic model_reset();
    ph = 0; mcnt = TAR; mcut = 0; mflash = 0;
    mdur  = '{TG1, TG2, TY, TAR};
    mpend = '{0, 0};
    mack  = '{0, 0};
  endtask

  task automatic model_step(bit tk, bit r1, bit r2, bit we, int addr, int data, bit nt);
    int  np;
    bit  cut;
    int  req [2];
    req  = '{int'(r1), int'(r2)};
    mack = '{0, 0};
    cut  = 1'b0;
    if (nt) begin
      mflash = (ph == 7) ? (mflash ^ int'(tk)) : 1;
      ph     = 7;
      mpend  = '{0, 0};
    end else if (ph == 7) begin
      ph = 0; mcnt = mdur[3]; mcut = 0;
      mpend = '{0, 0};
    end else if (tk && mcnt == 1) begin
      np = nxt_tab[ph];
      for (int r = 0; r < 2; r++) begin
        if (np == green_of[1 - r] && mpend[r] != 0) begin
          mack[r]  = 1;
          mpend[r] = 0;
        end else begin
          mpend[r] = mpend[r] | req[r];
        end
      end
      if (np == 1 || np == 4) mcut = 0;
      ph   = np;
      mcnt = mdur[didx_tab[np]];
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (ph == green_of[1 - r] && (mpend[r] | req[r]) != 0 && mcut == 0 && mcnt > PMIN)
          cut = 1'b1;
        mpend[r] = mpend[r] | req[r];
      end
      if (cut) begin
        mcnt = PMIN;
        mcut = 1;
      end else if (tk) begin
        mcnt--;
      end
    end
    if (we) mdur[addr] = (data == 0) ? 1 : data;
  endtask

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(tick, ped_req_1, ped_req_2, cfg_we, int'(cfg_addr), int'(cfg_data), night_now());
    #1;
    check("light_1", int'(light_1), lamp(0));
    check("light_2", int'(light_2), lamp(1));
    check("time_dis_1", int'(time_dis_1), disp(0));
    check("time_dis_2", int'(time_dis_2), disp(1));
    check("ped_ack_1", int'(ped_ack_1), mack[0]);
    check("ped_ack_2", int'(ped_ack_2), mack[1]);
    ack_cnt[0] += int'(ped_ack_1);
    ack_cnt[1] += int'(ped_ack_2);
  endtask

  task automatic tick_n(int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      cycle();
    end
  endtask

  task automatic wait_ph(int target);
    int k;
    k = 0;
    while (ph != target && k < 200) begin
      tick_n(1);
      k++;
    end
    check("wait_phase", ph, target);
  endtask

  task automatic check_outs(string name, int l1, int l2, int d1, int d2);
    check({name, ".light_1"}, int'(light_1), l1);
    check({name, ".light_2"}, int'(light_2), l2);
    check({name, ".time_dis_1"}, int'(time_dis_1), d1);
    check({name, ".time_dis_2"}, int'(time_dis_2), d2);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{0,  3'b100, 3'b100, 2,  2};
    tab[1] = '{1,  3'b100, 3'b100, 1,  1};
    tab[2] = '{1,  3'b001, 3'b100, 33, 35};
    tab[3] = '{29, 3'b001, 3'b100, 4,  6};
    tab[4] = '{1,  3'b010, 3'b100, 3,  5};
    tab[5] = '{3,  3'b100, 3'b100, 32, 2};
    tab[6] = '{2,  3'b100, 3'b001, 30, 28};
    tab[7] = '{25, 3'b100, 3'b010, 5,  3};
    tab[8] = '{3,  3'b100, 3'b100, 2,  37};
    tab[9] = '{2,  3'b001, 3'b100, 33, 35};

    model_reset();
    ack_cnt = '{0, 0};
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack_1", int'(ped_ack_1), 0);
    check("reset_ack_2", int'(ped_ack_2), 0);
    rst_n = 1'b1;

    // Default timing through a complete round.
    for (int i = 0; i < 10; i++) begin
      tick_n(tab[i].ticks);
      check_outs($sformatf("vec%0d", i), tab[i].l1, tab[i].l2, tab[i].d1, tab[i].d2);
    end

    // Pedestrian cut of G1 at cnt 20, ack on the next G1 entry.
    tick_n(10);
    check("g1_cnt20_d1", int'(time_dis_1), 23);
    ped_req_2 = 1'b1;
    cycle();
    ped_req_2 = 1'b0;
    check("ped_cut_d1", int'(time_dis_1), PMIN + TY);
    check("ped_cut_d2", int'(time_dis_2), PMIN + TY + TAR);
    ack_cnt = '{0, 0};
    tick_n(4);
    check("cut_still_g1", int'(light_1), 3'b001);
    tick_n(1);
    check("cut_y1", int'(light_1), 3'b010);
    wait_ph(1);
    check("ack2_count", ack_cnt[1], 1);
    check("ack1_none", ack_cnt[0], 0);

    // Requests at cnt 3: no cut; repeated request gives a single ack.
    tick_n(27);
    ped_req_1 = 1'b1;
    ped_req_2 = 1'b1;
    cycle();
    ped_req_1 = 1'b0;
    ped_req_2 = 1'b0;
    check("nocut_d1", int'(time_dis_1), 3 + TY);
    cycle();
    ped_req_1 = 1'b1;
    cycle();
    ped_req_1 = 1'b0;
    ack_cnt = '{0, 0};
    wait_ph(4);
    check("ack1_single", ack_cnt[0], 1);
    check("g2_full", int'(time_dis_2), TG2 + TY);
    wait_ph(1);
    wait_ph(4);
    check("ack1_once", ack_cnt[0], 1);
    check("ack2_once", ack_cnt[1], 1);

    // Config write mid-phase, zero write, and write colliding with a load.
    wait_ph(1);
    tick_n(15);
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 7'd10;
    cycle();
    cfg_we = 1'b0;
    check("cfg_run_d1", int'(time_dis_1), 15 + TY);
    check("cfg_run_d2", int'(time_dis_2), 15 + TY + TAR);
    tick_n(15);
    check("cfg_y1", int'(light_1), 3'b010);
    wait_ph(1);
    check("cfg_new_g1", int'(time_dis_1), 10 + TY);
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 7'd0;
    cycle();
    cfg_we = 1'b0;
    wait_ph(6);
    tick_n(1);
    tick = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 7'd7;
    cycle();
    tick = 1'b0; cfg_we = 1'b0;
    check("load_old_l1", int'(light_1), 3'b001);
    check("load_old_d1", int'(time_dis_1), 1 + TY);
    tick_n(1);
    check("zero_is_1s", int'(light_1), 3'b010);
    wait_ph(1);
    check("load_new_d1", int'(time_dis_1), 7 + TY);

    // Asynchronous reset in the middle of Y2.
    wait_ph(5);
    tick_n(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 3'b100, 3'b100, TAR, TAR);
    check("async_rst_ack", int'(ped_ack_1) + int'(ped_ack_2), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick_n(2);
    check_outs("after_rst", 3'b001, 3'b100, TG1 + TY, TG1 + TY + TAR);

`ifdef NIGHT_FLASH_EN
    night = 1'b1;
    cycle();
    check_outs("flash_on", 3'b010, 3'b010, 0, 0);
    ped_req_1 = 1'b1;
    tick_n(1);
    ped_req_1 = 1'b0;
    check_outs("flash_t1", 3'b000, 3'b000, 0, 0);
    tick_n(3);
    check_outs("flash_t4", 3'b010, 3'b010, 0, 0);
    night = 1'b0;
    cycle();
    check_outs("flash_off", 3'b100, 3'b100, TAR, TAR);
`endif

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      tick      = ($urandom_range(0, 2) == 0);
      ped_req_1 = ($urandom_range(0, 39) == 0);
      ped_req_2 = ($urandom_range(0, 39) == 0);
      cfg_we    = ($urandom_range(0, 59) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_data  = 7'($urandom_range(0, 15));
`ifdef NIGHT_FLASH_EN
      if ($urandom_range(0, 299) == 0) night = ~night;
`endif
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
